// File: rtl/la_rstseq.sv
// Multi-channel reset sequencer: async assert, synchronised and staggered release
// of N active-low reset channels, with a software re-sequence request.
module la_rstseq #(
  parameter     PROP   = "DEFAULT",
  parameter int STAGES = 2,
  parameter int N      = 4,
  parameter int GAP    = 8,
  parameter int HOLD   = 4,
  parameter int RND    = 1
) (
  input  logic         clk,
  input  logic         nrst_in,
  input  logic         swrst_req,
  output logic [N-1:0] nrst_out,
  output logic         ready
);

  localparam int CMAX = (GAP > HOLD) ? GAP : HOLD;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = $clog2(N) + 1;

  if (STAGES < 2 || N < 1 || GAP < 1 || HOLD < 1 || RND < 0) begin : g_bad_cfg
    $error("la_rstseq %s: illegal parameter set", PROP);
  end

  // In simulation an optional extra stage models metastability-resolution jitter.
`ifdef SIM
  localparam int XTRA = (RND != 0) ? 1 : 0;
`else
  localparam int XTRA = 0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEQ,
    S_DONE,
    S_HOLD
  } state_t;

  logic [STAGES-1+XTRA:0] sync_q, sync_d;
  logic                   rs;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N-1:0]           out_q, out_d;
  logic                   ready_q, ready_d;
  logic                   start_rel;
  logic                   go_hold;

  always_comb begin
    sync_d = {sync_q[STAGES-2+XTRA:0], 1'b1};
  end

  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef SIM
  logic rnd_sel_q;
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      rnd_sel_q <= 1'b0;
    end else begin
      rnd_sel_q <= (XTRA != 0) ? 1'($urandom) : 1'b0;
    end
  end
  assign rs = rnd_sel_q ? sync_q[STAGES-1+XTRA] : sync_q[STAGES-1];
`else
  assign rs = sync_q[STAGES-1];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    out_d     = out_q;
    ready_d   = ready_q;
    start_rel = 1'b0;
    go_hold   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_rel = rs;
      end
      S_SEQ: begin
        if (swrst_req) begin
          go_hold = 1'b1;
        end else if (cnt_q == CW'(GAP - 1)) begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) out_d[k] = 1'b1;
          end
          idx_d = idx_q + IW'(1);
          cnt_d = '0;
          if (idx_q == IW'(N - 1)) begin
            state_d = S_DONE;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        go_hold = swrst_req;
      end
      S_HOLD: begin
        if (cnt_q != CW'(HOLD - 1)) cnt_d = cnt_q + CW'(1);
        start_rel = !swrst_req && (cnt_q == CW'(HOLD - 1));
      end
    endcase

    // A release (from IDLE or after HOLD) always restarts with channel 0.
    if (start_rel) begin
      out_d    = '0;
      out_d[0] = 1'b1;
      idx_d    = IW'(1);
      cnt_d    = '0;
      state_d  = (N == 1) ? S_DONE : S_SEQ;
      ready_d  = (N == 1);
    end

    // Software request overrides any release scheduled for the same edge.
    if (go_hold) begin
      out_d   = '0;
      ready_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = S_HOLD;
    end
  end

  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign nrst_out = out_q;
  assign ready    = ready_q;

endmodule
